// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative 32-bit signed/unsigned restoring divider
// Magnitudes are divided in CALC (one bit per cycle); signs and divide-by-zero are resolved in FIX.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam int         CW     = $clog2(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] orig_q, orig_d;
  logic [CW-1:0]    count_q, count_d;
  logic             qsign_q, qsign_d;
  logic             rsign_q, rsign_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic             dvd_neg, dvs_neg;
  logic [WIDTH:0]   shifted;
  logic             ge;

  assign dvd_neg = is_signed & dividend[WIDTH-1];
  assign dvs_neg = is_signed & divisor[WIDTH-1];

  // The partial remainder is always below the divisor, so its top bit is free for the shift.
  assign shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign ge      = (shifted >= {1'b0, dvsr_q});

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    orig_d  = orig_q;
    count_d = count_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    zero_d  = zero_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          orig_d  = dividend;
          rem_d   = '0;
          count_d = '0;
          if (divisor == '0) begin
            zero_d  = 1'b1;
            state_d = S_FIX;
          end else begin
            zero_d  = 1'b0;
            quo_d   = dvd_neg ? (~dividend + 1'b1) : dividend;
            dvsr_d  = dvs_neg ? (~divisor + 1'b1) : divisor;
            qsign_d = dvd_neg ^ dvs_neg;
            rsign_d = dvd_neg;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        rem_d   = ge ? (shifted - {1'b0, dvsr_q}) : shifted;
        quo_d   = {quo_q[WIDTH-2:0], ge};
        count_d = count_q + 1'b1;
        if (count_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (zero_q) begin
          quot_d = '1;
          remo_d = orig_q;
          dbz_d  = 1'b1;
        end else begin
          quot_d = qsign_q ? (~quo_q + 1'b1) : quo_q;
          remo_d = rsign_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
          dbz_d  = 1'b0;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      orig_q  <= '0;
      count_q <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      zero_q  <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      orig_q  <= orig_d;
      count_q <= count_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      zero_q  <= zero_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
module tb_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_checks;
  int n_errors;
  int lat;
  int busy_n;
  logic seen_done;

  div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive start for one edge (E0); returns #1 after E0 with start released.
  task automatic launch(input logic [31:0] dvd, input logic [31:0] dvs, input logic sgn);
    @(negedge clk);
    dividend  = dvd;
    divisor   = dvs;
    is_signed = sgn;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Cycles from the current sample point until done is seen, plus busy cycles including this one.
  task automatic wait_done(output int l, output int b);
    l = 0;
    b = busy ? 1 : 0;
    while (!done && l < 100) begin
      @(posedge clk);
      #1;
      l++;
      if (busy) b++;
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_quot", quotient, 32'd0);
    check("reset_rem", remainder, 32'd0);
    check("reset_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Unsigned 100 / 7
    launch(32'd100, 32'd7, 1'b0);
    check("u100_busy_e0", {31'd0, busy}, 32'd1);
    wait_done(lat, busy_n);
    check("u100_latency", lat, 32'd33);
    check("u100_busy_cycles", busy_n, 32'd33);
    check("u100_busy_at_done", {31'd0, busy}, 32'd0);
    check("u100_quot", quotient, 32'd14);
    check("u100_rem", remainder, 32'd2);
    check("u100_dbz", {31'd0, div_by_zero}, 32'd0);
    @(posedge clk);
    #1;
    check("u100_done_one_cycle", {31'd0, done}, 32'd0);

    // Signed -7 / 2
    launch(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done(lat, busy_n);
    check("s_m7_2_quot", quotient, 32'hFFFF_FFFD);
    check("s_m7_2_rem", remainder, 32'hFFFF_FFFF);

    // Signed 7 / -2
    launch(32'd7, 32'hFFFF_FFFE, 1'b1);
    wait_done(lat, busy_n);
    check("s_7_m2_quot", quotient, 32'hFFFF_FFFD);
    check("s_7_m2_rem", remainder, 32'd1);

    // Signed overflow
    launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done(lat, busy_n);
    check("s_ovf_quot", quotient, 32'h8000_0000);
    check("s_ovf_rem", remainder, 32'd0);
    check("s_ovf_dbz", {31'd0, div_by_zero}, 32'd0);

    // Same operands unsigned
    launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_done(lat, busy_n);
    check("u_big_quot", quotient, 32'd0);
    check("u_big_rem", remainder, 32'h8000_0000);

    // Divide by zero
    launch(32'h0000_1234, 32'd0, 1'b1);
    check("dz_busy_e0", {31'd0, busy}, 32'd1);
    wait_done(lat, busy_n);
    check("dz_latency", lat, 32'd1);
    check("dz_busy_at_done", {31'd0, busy}, 32'd0);
    check("dz_quot", quotient, 32'hFFFF_FFFF);
    check("dz_rem", remainder, 32'h0000_1234);
    check("dz_flag", {31'd0, div_by_zero}, 32'd1);

    // Next normal divide clears the flag
    launch(32'd50, 32'd5, 1'b0);
    wait_done(lat, busy_n);
    check("after_dz_flag", {31'd0, div_by_zero}, 32'd0);
    check("after_dz_quot", quotient, 32'd10);
    check("after_dz_rem", remainder, 32'd0);

    // Start pulse mid-divide is ignored
    launch(32'd1000, 32'd3, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    dividend = 32'd77;
    divisor  = 32'd11;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ign_quot_held", quotient, 32'd10);
    wait_done(lat, busy_n);
    check("ign_latency_rest", lat, 32'd23);
    check("ign_quot", quotient, 32'd333);
    check("ign_rem", remainder, 32'd1);

    // Start held through the done cycle: back-to-back accept
    dividend  = 32'd77;
    divisor   = 32'd11;
    is_signed = 1'b0;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_done_low", {31'd0, done}, 32'd0);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done(lat, busy_n);
    check("b2b_latency", lat, 32'd33);
    check("b2b_quot", quotient, 32'd7);
    check("b2b_rem", remainder, 32'd0);

    // Reset during a divide
    launch(32'd999, 32'd10, 1'b0);
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    check("rst_mid_quot", quotient, 32'd0);
    check("rst_mid_rem", remainder, 32'd0);
    check("rst_mid_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) seen_done = 1'b1;
    end
    check("rst_no_done", {31'd0, seen_done}, 32'd0);
    launch(32'hFFFF_FF9C, 32'd7, 1'b1);
    wait_done(lat, busy_n);
    check("rst_fresh_latency", lat, 32'd33);
    check("rst_fresh_quot", quotient, 32'hFFFF_FFF2);
    check("rst_fresh_rem", remainder, 32'hFFFF_FFFE);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit signed/unsigned divider for the CPU datapath. It sits directly upstream of the six-input writeback select mux: `quotient` and `remainder` drive two of that mux's 32-bit data inputs (the LO/HI slots, select codes 3'b100 and 3'b101). It uses a start/busy/done handshake so the stall logic can hold the pipeline while a division is in flight.

## Interface
- `WIDTH`, default 32: operand and result width. Only 32 is verified.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a division; sampled only in IDLE.
- `is_signed`  in  1  1 = two's-complement operands, 0 = unsigned; sampled with `start`.
- `dividend`  in  32  numerator; sampled with `start`.
- `divisor`  in  32  denominator; sampled with `start`.
- `busy`  out  1  division in progress; stall request to the pipeline.
- `done`  out  1  one-cycle pulse; results are valid and updated in this cycle.
- `quotient`  out  32  registered quotient; holds until the next `done`.
- `remainder`  out  32  registered remainder; holds until the next `done`.
- `div_by_zero`  out  1  registered flag for the last completed operation.

## Operation
- States: IDLE, CALC, FIX.
- IDLE:
  - `start`=1 with `divisor`≠0: latch |dividend| and |divisor| (absolute values only when `is_signed`), the quotient sign (sign XOR) and the remainder sign (dividend sign). Clear the partial remainder and set count=0. Go to CALC.
  - `start`=1 with `divisor`=0: go directly to FIX with the zero-divide flag set.
- CALC: one restoring step per cycle.
  - Shift {rem, quo} left by 1 and bring in the dividend MSB.
  - If rem ≥ divisor: subtract, and the quotient bit = 1.
  - After 32 steps (count 31 → wrap) go to FIX.
- FIX:
  - Apply sign correction. The quotient is negated if the quotient sign is set. The remainder is negated if the remainder sign is set. Division truncates toward zero, and the remainder takes the sign of the dividend.
  - Write `quotient`, `remainder` and `div_by_zero`. Pulse `done`. Go to IDLE.
- Divide by zero: `quotient`=32'hFFFF_FFFF, `remainder`=original dividend, `div_by_zero`=1, for both signed and unsigned.
- Signed overflow (0x8000_0000 / 0xFFFF_FFFF): `quotient`=32'h8000_0000, `remainder`=0, `div_by_zero`=0. This falls out of the unsigned magnitude path and needs no special case.
- Unsigned operands are never negated. The internal partial remainder is 33 bits so that compare and subtract never overflow.
- `start` while `busy`=1 is ignored. There is no queueing and no abort.

## Timing
- Reset values: `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, state IDLE, internal registers 0.
- Asserting `rst_n` mid-operation drops the operation. Outputs return to their reset values immediately, with no `done`.
- Edge E0 samples `start`. `busy` is 1 from E0 until E33. CALC steps run on edges E1–E32. E33 (FIX) registers the results, sets `done`=1 and `busy`=0. Latency is 33 cycles from the start edge to the done cycle.
- Divide-by-zero path: `busy`=1 after E0. E1 registers the results with `done`=1 and `busy`=0. Latency is 1 cycle.
- `done` is high for exactly one cycle. `quotient` and `remainder` change only on the edge that raises `done`.
- Back-to-back: `start` held high during the `done` cycle is accepted at that edge. The next result arrives 33 cycles later.
- `busy` and `done` are never both 1.

## Test plan
- Unsigned 100 / 7: `done` arrives 33 cycles after `start`. Required: `quotient`=14, `remainder`=2, `busy` high for exactly 33 cycles.
- Signed −7 / 2 (0xFFFF_FFF9 / 2): `quotient`=0xFFFF_FFFD (−3), `remainder`=0xFFFF_FFFF (−1). Signed 7 / −2: `quotient`=−3, `remainder`=1.
- Signed 0x8000_0000 / 0xFFFF_FFFF: `quotient`=0x8000_0000, `remainder`=0. The same operands unsigned: `quotient`=0, `remainder`=0x8000_0000.
- Divide by zero, 0x1234 / 0: `done` 1 cycle after `start`, `quotient`=0xFFFF_FFFF, `remainder`=0x1234, `div_by_zero`=1. The next normal divide clears `div_by_zero`.
- Pulse `start` with new operands at cycle 10 of a running divide: the pulse is ignored and the first result is unchanged. Then hold `start` through the `done` cycle: the second division is accepted and completes 33 cycles later.
- Drive `rst_n` low at cycle 20 of a divide: all outputs are 0 immediately, no `done` pulse appears, and the unit accepts a fresh `start` after release.
